collision_scanner: RTL
======================

# collision_scanner

Sequential multi-object collision detector for the race game: on each `start` it compares one player rectangle against `N_OBJ` obstacle/opponent rectangles read one per cycle from an external object table, and reports a per-object hit mask, a "new this frame" mask, an any-hit flag and the lowest hit index. It sits between the object-position table and the game-state controller, and is normally started once per frame at vertical blank. All rectangles are centre-based (x, y, w, h). Edge clamping and overlap are computed exactly, with no wrap-around.

## Interface

Parameters:
- `N_OBJ`, 8, number of objects scanned (2..64)
- `XW`, 10, x coordinate / width bit width
- `YW`, 9, y coordinate / height bit width
- `IW`, derived = clog2(`N_OBJ`), index width (localparam, not overridable)

Ports:
- `clk` in 1, system clock; single clock domain
- `rst_n` in 1, reset, asynchronous assert, active-low
- `start` in 1, single-cycle scan request; honoured only while `busy`=0
- `px`, `py` in XW / YW, player centre; sampled on accepted `start`
- `pw`, `ph` in XW / YW, player width / height; sampled on accepted `start`
- `busy` out 1, scan in progress
- `obj_rd` out 1, object table read strobe
- `obj_idx` out IW, object index being read
- `obj_x`, `obj_y` in XW / YW, object centre; valid the cycle after `obj_rd`
- `obj_w`, `obj_h` in XW / YW, object size; valid the cycle after `obj_rd`
- `obj_active` in 1, object present; valid the cycle after `obj_rd`; inactive objects never hit
- `done` out 1, one-cycle pulse when results update
- `hit_mask` out N_OBJ, bit i = object i overlaps player
- `new_hit_mask` out N_OBJ, `hit_mask` & ~(previous scan's `hit_mask`)
- `hit_any` out 1, OR of `hit_mask`
- `first_hit` out IW, lowest set index in `hit_mask`; 0 when `hit_any`=0

## Operation

- States: IDLE, SCAN, LAST, DONE.
  - IDLE: on `start`, latch player rectangle, clear the scratch mask, go to SCAN.
  - SCAN: `obj_rd`=1 with `obj_idx` counting 0..N_OBJ-1, one per cycle; after issuing N_OBJ-1, go to LAST.
  - LAST: evaluate the final returned object, then go to DONE.
  - DONE: publish results, pulse `done`, return to IDLE.
- Compare is pipelined: the object read at cycle k is evaluated at cycle k+1 and written into scratch-mask bit k.
- Edge arithmetic uses XW+1 / YW+1 bits so nothing wraps. Half sizes are floor(w/2), floor(h/2).
  - left = x − w/2, saturated at 0.
  - right = x + w/2, unsaturated in the widened width.
  - top and bottom are computed the same way.
- Hit when all of these hold: `obj_active`, A.left ≤ B.right, B.left ≤ A.right, A.top ≤ B.bottom, B.top ≤ A.bottom. Inclusive, so touching edges count as a hit. Zero-size rectangles are points.
- `start` while `busy`=1 is ignored; it is not queued.
- Outputs `hit_mask`, `new_hit_mask`, `hit_any`, `first_hit` are registered. They change only in the DONE cycle and hold until the next DONE.
- A history register holds the last published `hit_mask` and is used for `new_hit_mask`.
- Player inputs may change freely after the `start` cycle.

## Timing

- Reset values: all outputs 0, history 0, state IDLE, `obj_idx` 0.
- `start` sampled at edge 0. `busy` and `obj_rd` are high from cycle 1. `obj_idx`=k in cycle 1+k.
- `obj_rd` is low in cycle N_OBJ+1 (LAST). `busy` stays high through LAST.
- `done` is high in cycle N_OBJ+2, with new results visible that same cycle. `busy`=0 in that cycle, so a new `start` is accepted there. Throughput is one scan per N_OBJ+2 cycles.
- Reset mid-scan: immediate return to IDLE and all outputs 0. The history is cleared, so the first scan after reset reports `new_hit_mask` = `hit_mask`.
- No partial results are ever published.

## Test plan

- Touching edge: player (100,100,20,20), object 3 = (115,100,10,10) active, all others inactive → `done` at cycle 10 (N_OBJ=8), `hit_mask`=0x08, `hit_any`=1, `first_hit`=3.
- Miss by one: same setup but object 3 x=116 → `hit_mask`=0, `first_hit`=0. Also object 3 x=115 with `obj_active`=0 → no hit.
- Saturation and no wrap:
  - Player (5,5,20,20) vs object 0 = (0,0,4,4) → hit.
  - Player (1020,470,20,20) vs object 7 = (1023,479,0,0) → hit.
  - Object 1 = (2,2,0,0) vs player (1020,470,20,20) → no hit (checks for wrap).
- New-hit tracking: scan 1 hits {2,5} → `new_hit_mask`=0x24. Scan 2 hits {5,6} → `new_hit_mask`=0x40, `first_hit`=5.
- Handshake: `start` pulsed at cycles 0, 4 and 10 → only two scans. `done` at cycles 10 and 20, `obj_idx` sequence 0..7 twice, with the second scan starting at cycle 11.
- Reset mid-scan: deassert `rst_n` in cycle 5 → outputs 0 asynchronously, no `done`. The next scan reports `new_hit_mask` equal to `hit_mask`.

Source files
------------

// File: rtl/collision_scanner_if.sv
// Bundle of the scan-request, object-table and result signals of the
// collision scanner. The master side requests scans and serves the object
// table; the slave side is the scanner itself.
interface collision_scanner_if #(
    parameter int N_OBJ = 8,
    parameter int XW    = 10,
    parameter int YW    = 9
);
    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic              start;
    logic [XW-1:0]     px;
    logic [YW-1:0]     py;
    logic [XW-1:0]     pw;
    logic [YW-1:0]     ph;
    logic              busy;
    logic              obj_rd;
    logic [IW-1:0]     obj_idx;
    logic [XW-1:0]     obj_x;
    logic [YW-1:0]     obj_y;
    logic [XW-1:0]     obj_w;
    logic [YW-1:0]     obj_h;
    logic              obj_active;
    logic              done;
    logic [N_OBJ-1:0]  hit_mask;
    logic [N_OBJ-1:0]  new_hit_mask;
    logic              hit_any;
    logic [IW-1:0]     first_hit;

    modport master (
        output start, px, py, pw, ph,
        output obj_x, obj_y, obj_w, obj_h, obj_active,
        input  busy, obj_rd, obj_idx,
        input  done, hit_mask, new_hit_mask, hit_any, first_hit
    );

    modport slave (
        input  start, px, py, pw, ph,
        input  obj_x, obj_y, obj_w, obj_h, obj_active,
        output busy, obj_rd, obj_idx,
        output done, hit_mask, new_hit_mask, hit_any, first_hit
    );
endinterface

// File: rtl/collision_scanner.sv
// Sequential player-vs-objects rectangle overlap scanner. Reads one object
// per cycle from an external table, evaluates it the following cycle and
// publishes the complete hit mask (plus new-hit, any-hit, first-hit) at once.
module collision_scanner #(
    parameter int N_OBJ = 8,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    collision_scanner_if.slave   bus
);
    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LAST, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              rd_valid_q, rd_valid_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [XW-1:0]     px_q, px_d, pw_q, pw_d;
    logic [YW-1:0]     py_q, py_d, ph_q, ph_d;
    logic [N_OBJ-1:0]  scratch_q, scratch_d;
    // hit_mask_q doubles as the history of the last published mask
    logic [N_OBJ-1:0]  hit_mask_q, hit_mask_d;
    logic [N_OBJ-1:0]  new_hit_q, new_hit_d;
    logic              hit_any_q, hit_any_d;
    logic [IW-1:0]     first_hit_q, first_hit_d;

    logic [XW:0]       p_l, p_r, o_l, o_r;
    logic [YW:0]       p_t, p_b, o_t, o_b;
    logic              obj_hit;

    // Widened edge arithmetic: low edges saturate at 0, high edges never wrap
    always_comb begin
        p_l = (px_q >= (pw_q >> 1)) ? {1'b0, px_q - (pw_q >> 1)} : '0;
        p_r = {1'b0, px_q} + {2'b0, pw_q[XW-1:1]};
        p_t = (py_q >= (ph_q >> 1)) ? {1'b0, py_q - (ph_q >> 1)} : '0;
        p_b = {1'b0, py_q} + {2'b0, ph_q[YW-1:1]};
        o_l = (bus.obj_x >= (bus.obj_w >> 1)) ? {1'b0, bus.obj_x - (bus.obj_w >> 1)} : '0;
        o_r = {1'b0, bus.obj_x} + {2'b0, bus.obj_w[XW-1:1]};
        o_t = (bus.obj_y >= (bus.obj_h >> 1)) ? {1'b0, bus.obj_y - (bus.obj_h >> 1)} : '0;
        o_b = {1'b0, bus.obj_y} + {2'b0, bus.obj_h[YW-1:1]};
        obj_hit = bus.obj_active && (p_l <= o_r) && (o_l <= p_r)
                  && (p_t <= o_b) && (o_t <= p_b);
    end

    // Next-state, read sequencing, scratch accumulation and result publishing
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_valid_d  = 1'b0;
        rd_idx_d    = idx_q;
        px_d        = px_q;
        py_d        = py_q;
        pw_d        = pw_q;
        ph_d        = ph_q;
        scratch_d   = scratch_q;
        hit_mask_d  = hit_mask_q;
        new_hit_d   = new_hit_q;
        hit_any_d   = hit_any_q;
        first_hit_d = first_hit_q;

        // Object read in the previous cycle returns now; record its verdict
        if (rd_valid_q && obj_hit) begin
            scratch_d[rd_idx_q] = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    px_d      = bus.px;
                    py_d      = bus.py;
                    pw_d      = bus.pw;
                    ph_d      = bus.ph;
                    scratch_d = '0;
                    idx_d     = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                rd_valid_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_LAST;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_LAST: begin
                // Final object folds in here so DONE sees the complete mask
                hit_mask_d  = scratch_d;
                new_hit_d   = scratch_d & ~hit_mask_q;
                hit_any_d   = |scratch_d;
                first_hit_d = '0;
                for (int i = N_OBJ - 1; i >= 0; i--) begin
                    if (scratch_d[i]) begin
                        first_hit_d = IW'(i);
                    end
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears results and history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            px_q        <= '0;
            py_q        <= '0;
            pw_q        <= '0;
            ph_q        <= '0;
            scratch_q   <= '0;
            hit_mask_q  <= '0;
            new_hit_q   <= '0;
            hit_any_q   <= 1'b0;
            first_hit_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_idx_q    <= rd_idx_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pw_q        <= pw_d;
            ph_q        <= ph_d;
            scratch_q   <= scratch_d;
            hit_mask_q  <= hit_mask_d;
            new_hit_q   <= new_hit_d;
            hit_any_q   <= hit_any_d;
            first_hit_q <= first_hit_d;
        end
    end

    assign bus.busy         = (state_q == S_SCAN) || (state_q == S_LAST);
    assign bus.obj_rd       = (state_q == S_SCAN);
    assign bus.obj_idx      = idx_q;
    assign bus.done         = (state_q == S_DONE);
    assign bus.hit_mask     = hit_mask_q;
    assign bus.new_hit_mask = new_hit_q;
    assign bus.hit_any      = hit_any_q;
    assign bus.first_hit    = first_hit_q;
endmodule
